// File: rtl/prbs_pkg.sv
// Shared types and defaults for the PRBS sequencer.
package prbs_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int         DEFAULT_WIDTH = 8;
  localparam logic [7:0] DEFAULT_TAPS  = 8'hB8;
endpackage

// File: rtl/prbs_seq_ctrl_if.sv
// Host/config and bit-stream bundle between the sequencer and its neighbours.
interface prbs_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 16,
  parameter int CNT_W = 32
);
  logic             seed_valid;
  logic [WIDTH-1:0] seed_data;
  logic             seed_ready;
  logic             cmd_start;
  logic             cmd_stop;
  logic [LEN_W-1:0] burst_len;
  logic             bit_valid;
  logic             bit_ready;
  logic             bit_data;
  logic             busy;
  logic             done;
  logic             seed_err;
  logic [WIDTH-1:0] lfsr_q;
  logic [CNT_W-1:0] bit_count;

  modport slave (
    input  seed_valid, seed_data, cmd_start, cmd_stop, burst_len, bit_ready,
    output seed_ready, bit_valid, bit_data, busy, done, seed_err, lfsr_q, bit_count
  );
  modport master (
    output seed_valid, seed_data, cmd_start, cmd_stop, burst_len, bit_ready,
    input  seed_ready, bit_valid, bit_data, busy, done, seed_err, lfsr_q, bit_count
  );
endinterface

// File: rtl/prbs_lfsr_core.sv
// Fibonacci LFSR register: load has priority over step, resets to 1.
module prbs_lfsr_core #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i)      q_d = load_val_i;
    else if (step_i) q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= WIDTH'(1);
    else         q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/prbs_seq_ctrl.sv
// PRBS sequencer: seeds the LFSR, steps it per accepted bit, runs bursts or continuous streams.
module prbs_seq_ctrl
  import prbs_pkg::*;
#(
  parameter int               WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
  parameter int               LEN_W = 16,
  parameter int               CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  prbs_seq_ctrl_if.slave  bus
);
  state_e           state_q;
  logic             seeded_q;
  logic [LEN_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q, seed_err_q;
  logic [WIDTH-1:0] lfsr;
  logic             seed_hs, bit_hs, seed_zero;

  assign seed_hs   = (state_q == IDLE) && bus.seed_valid;
  assign bit_hs    = (state_q == RUN) && bus.bit_ready;
  assign seed_zero = (bus.seed_data == '0);

  // A zero seed would lock the LFSR at zero, so 1 is loaded in its place.
  prbs_lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_core (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (seed_hs),
    .load_val_i (seed_zero ? WIDTH'(1) : bus.seed_data),
    .step_i     (bit_hs),
    .q_o        (lfsr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      seeded_q   <= 1'b0;
      rem_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      seed_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (seed_hs) begin
            seeded_q   <= 1'b1;
            cnt_q      <= '0;
            seed_err_q <= seed_zero;
          end
          if (bus.cmd_start && (seeded_q || seed_hs)) begin
            state_q <= RUN;
            rem_q   <= bus.burst_len;
          end
        end
        RUN: begin
          if (bit_hs) begin
            if (!(&cnt_q))   cnt_q <= cnt_q + 1'b1;
            if (rem_q != '0) rem_q <= rem_q - 1'b1;
          end
          // Final burst handshake wins over a coincident stop.
          if (bit_hs && rem_q == LEN_W'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (bus.cmd_stop) begin
            state_q <= IDLE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.seed_ready = (state_q == IDLE);
  assign bus.bit_valid  = (state_q == RUN);
  assign bus.busy       = (state_q == RUN);
  assign bus.bit_data   = lfsr[WIDTH-1];
  assign bus.lfsr_q     = lfsr;
  assign bus.bit_count  = cnt_q;
  assign bus.done       = done_q;
  assign bus.seed_err   = seed_err_q;
endmodule
